// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and the
// default 1 MBaud divider used by uart_tx, uart_rx and the top level.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int UART_DATA_W       = 8;
  localparam int CLKDIV_1MBAUD_60M = 59;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pins; resets to all ones so an
// idle-high line never looks like an edge coming out of reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // metastability chain
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= '1;
      sync_r <= '1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling with a down-counting bit
// timer. CLKDIV is clocks per bit minus one and must be at least 3.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKDIV = CLKDIV_1MBAUD_60M
) (
  input  logic                   clk60,
  input  logic                   rst,
  input  logic                   rx_pin,
  output logic [UART_DATA_W-1:0] rxdata,
  output logic                   rx_valid,
  output logic                   frame_err,
  output logic                   rx_busy
);

  localparam int             CNT_W    = $clog2(CLKDIV + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKDIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKDIV >> 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic                   rx_s;
  logic                   rx_prev_r;
  rx_state_e              state_r;
  rx_state_e              state_nxt;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nxt;
  logic [2:0]             bit_idx_r;
  logic [2:0]             bit_idx_nxt;
  logic [UART_DATA_W-1:0] shreg_r;
  logic [UART_DATA_W-1:0] shreg_nxt;
  logic [UART_DATA_W-1:0] rxdata_r;
  logic [UART_DATA_W-1:0] rxdata_nxt;
  logic                   rx_valid_r;
  logic                   rx_valid_nxt;
  logic                   frame_err_r;
  logic                   frame_err_nxt;
  logic                   rx_busy_r;
  logic                   rx_busy_nxt;
  logic                   cnt_zero;
  logic                   fall_edge;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk(clk60),
    .rst(rst),
    .d  (rx_pin),
    .q  (rx_s)
  );

  assign cnt_zero  = (cnt_r == CNT_ZERO);
  assign fall_edge = (rx_s == 1'b0) && (rx_prev_r == 1'b1);

  // state register, bit timer, shift register and registered outputs
  always_ff @(posedge clk60) begin
    if (rst) begin
      rx_prev_r   <= 1'b1;
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      bit_idx_r   <= 3'd0;
      shreg_r     <= 8'h00;
      rxdata_r    <= 8'h00;
      rx_valid_r  <= 1'b0;
      frame_err_r <= 1'b0;
      rx_busy_r   <= 1'b0;
    end else begin
      rx_prev_r   <= rx_s;
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      bit_idx_r   <= bit_idx_nxt;
      shreg_r     <= shreg_nxt;
      rxdata_r    <= rxdata_nxt;
      rx_valid_r  <= rx_valid_nxt;
      frame_err_r <= frame_err_nxt;
      rx_busy_r   <= rx_busy_nxt;
    end
  end

  // next-state and datapath update
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    bit_idx_nxt = bit_idx_r;
    shreg_nxt   = shreg_r;
    case (state_r)
      IDLE: begin
        if (fall_edge) begin
          state_nxt = START;
          cnt_nxt   = CNT_HALF;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt_r - CNT_ONE;
        end else if (rx_s == 1'b0) begin
          state_nxt   = DATA;
          cnt_nxt     = CNT_FULL;
          bit_idx_nxt = 3'd0;
        end else begin
          // start bit gone by mid-bit: treat as a glitch
          state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt_r - CNT_ONE;
        end else begin
          shreg_nxt = {rx_s, shreg_r[UART_DATA_W-1:1]};
          cnt_nxt   = CNT_FULL;
          if (bit_idx_r == 3'd7) begin
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx_r + 3'd1;
          end
        end
      end
      STOP: begin
        if (!cnt_zero) begin
          cnt_nxt = cnt_r - CNT_ONE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // output decode, registered on the next edge
  always_comb begin
    rxdata_nxt    = rxdata_r;
    rx_valid_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    if ((state_r == STOP) && cnt_zero) begin
      if (rx_s == 1'b1) begin
        rxdata_nxt   = shreg_r;
        rx_valid_nxt = 1'b1;
      end else begin
        frame_err_nxt = 1'b1;
      end
    end else begin
      rxdata_nxt = rxdata_r;
    end
    rx_busy_nxt = (state_nxt != IDLE);
  end

  assign rxdata    = rxdata_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
  assign rx_busy   = rx_busy_r;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 1 MBaud instance for framing, timing and
// error cases, plus a fast instance for a 256-byte incrementing stream.
module tb_uart_rx;

  logic       clk60;
  logic       rst;
  logic       rx_pin;
  logic       rx_pin2;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;
  logic [7:0] rxdata2;
  logic       rx_valid2;
  logic       frame_err2;
  logic       rx_busy2;

  int checks = 0;
  int errors = 0;

  int     valid_cnt = 0;
  int     ferr_cnt = 0;
  int     viol_cnt = 0;
  bit     prev_evt = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  longint valid_t = 0;
  longint prev_valid_t = 0;
  longint fall_t = 0;

  int     valid2_cnt = 0;
  int     ferr2_cnt = 0;
  int     mism2_cnt = 0;
  int     exp2 = 0;

  uart_rx #(.CLKDIV(59)) dut (
    .clk60    (clk60),
    .rst      (rst),
    .rx_pin   (rx_pin),
    .rxdata   (rxdata),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  uart_rx #(.CLKDIV(7)) dut_fast (
    .clk60    (clk60),
    .rst      (rst),
    .rx_pin   (rx_pin2),
    .rxdata   (rxdata2),
    .rx_valid (rx_valid2),
    .frame_err(frame_err2),
    .rx_busy  (rx_busy2)
  );

  initial clk60 = 1'b0;
  always #5 clk60 = ~clk60;

  // event monitor on the falling edge, away from the active edge
  always @(negedge clk60) begin
    if (rx_valid) begin
      valid_cnt++;
      prev_data    = last_data;
      last_data    = rxdata;
      prev_valid_t = valid_t;
      valid_t      = $time;
    end
    if (frame_err) ferr_cnt++;
    if ((rx_valid && frame_err) || ((rx_valid || frame_err) && prev_evt)) viol_cnt++;
    prev_evt = rx_valid || frame_err;
    if (rx_valid2) begin
      valid2_cnt++;
      if (rxdata2 !== exp2[7:0]) mism2_cnt++;
      exp2++;
    end
    if (frame_err2) ferr2_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input longint val, input longint lo, input longint hi);
    checks++;
    assert ((val >= lo) && (val <= hi)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    rx_pin  = 1'b1;
    rx_pin2 = 1'b1;
    repeat (n) @(posedge clk60);
  endtask

  // drive one frame starting right after a posedge; ends on a posedge
  task automatic send_frame(input bit sel, input logic [7:0] d, input int cpb, input bit stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (sel) rx_pin2 = f[i];
      else     rx_pin  = f[i];
      if (i == 0 && !sel) fall_t = $time;
      repeat (cpb) @(posedge clk60);
    end
  endtask

  int         v0;
  int         f0;
  logic [9:0] frame;

  initial begin
    rst     = 1'b1;
    rx_pin  = 1'b1;
    rx_pin2 = 1'b1;
    repeat (4) @(posedge clk60);
    @(negedge clk60);
    chk("reset_rxdata", 32'(rxdata), 32'h00);
    chk("reset_valid", 32'(rx_valid), 32'd0);
    chk("reset_ferr", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(rx_busy), 32'd0);
    @(posedge clk60);
    rst = 1'b0;

    // single frame 0x55
    idle(20);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(1'b0, 8'h55, 60, 1'b1);
    idle(100);
    @(negedge clk60);
    chk("single_count", 32'(valid_cnt - v0), 32'd1);
    chk("single_data", 32'(last_data), 32'h55);
    chk_range("single_latency", (valid_t - fall_t) / 10, 570, 574);
    chk("single_ferr", 32'(ferr_cnt - f0), 32'd0);

    // back-to-back 0x00 then 0xFF, no gap
    idle(20);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(1'b0, 8'h00, 60, 1'b1);
    send_frame(1'b0, 8'hFF, 60, 1'b1);
    idle(100);
    @(negedge clk60);
    chk("b2b_count", 32'(valid_cnt - v0), 32'd2);
    chk("b2b_first", 32'(prev_data), 32'h00);
    chk("b2b_second", 32'(last_data), 32'hFF);
    chk_range("b2b_spacing", (valid_t - prev_valid_t) / 10, 598, 602);
    chk("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 10-cycle glitch
    idle(50);
    v0 = valid_cnt; f0 = ferr_cnt;
    rx_pin = 1'b0;
    repeat (10) @(posedge clk60);
    rx_pin = 1'b1;
    repeat (5) @(posedge clk60);
    @(negedge clk60);
    chk("glitch_busy_mid", 32'(rx_busy), 32'd1);
    repeat (40) @(posedge clk60);
    @(negedge clk60);
    chk("glitch_busy_end", 32'(rx_busy), 32'd0);
    idle(600);
    @(negedge clk60);
    chk("glitch_valid", 32'(valid_cnt - v0), 32'd0);
    chk("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

    // framing error 0xA5 with low stop bit, line held low
    @(posedge clk60);
    idle(50);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(1'b0, 8'hA5, 60, 1'b0);
    repeat (2000) @(posedge clk60);
    @(negedge clk60);
    chk("ferr_count", 32'(ferr_cnt - f0), 32'd1);
    chk("ferr_valid", 32'(valid_cnt - v0), 32'd0);
    chk("ferr_rxdata", 32'(rxdata), 32'hFF);
    chk("ferr_busy", 32'(rx_busy), 32'd0);

    // recovery after line release
    @(posedge clk60);
    idle(100);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(1'b0, 8'h3C, 60, 1'b1);
    idle(100);
    @(negedge clk60);
    chk("recover_count", 32'(valid_cnt - v0), 32'd1);
    chk("recover_data", 32'(rxdata), 32'h3C);
    chk("recover_ferr", 32'(ferr_cnt - f0), 32'd0);

    // reset pulse in the middle of data bit 4 of 0x81
    @(posedge clk60);
    idle(50);
    frame = {1'b1, 8'h81, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_pin = frame[i];
      for (int k = 0; k < 60; k++) begin
        if (i == 5 && k == 31) begin
          @(negedge clk60);
          chk("midrst_rxdata", 32'(rxdata), 32'h00);
          chk("midrst_valid", 32'(rx_valid), 32'd0);
          chk("midrst_ferr", 32'(frame_err), 32'd0);
          chk("midrst_busy", 32'(rx_busy), 32'd0);
        end
        rst = (i == 5 && k == 30);
        @(posedge clk60);
      end
    end
    rst = 1'b0;
    idle(1500);
    send_frame(1'b0, 8'h81, 60, 1'b1);
    idle(100);
    @(negedge clk60);
    chk("midrst_refill", 32'(rxdata), 32'h81);
    chk_range("midrst_latency", (valid_t - fall_t) / 10, 570, 574);

    // baud tolerance
    @(posedge clk60);
    idle(100);
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(1'b0, 8'hC3, 57, 1'b1);
    idle(200);
    @(negedge clk60);
    chk("baud57_data", 32'(rxdata), 32'hC3);
    chk("baud57_count", 32'(valid_cnt - v0), 32'd1);
    @(posedge clk60);
    idle(100);
    v0 = valid_cnt;
    send_frame(1'b0, 8'hC3, 63, 1'b1);
    idle(200);
    @(negedge clk60);
    chk("baud63_data", 32'(rxdata), 32'hC3);
    chk("baud63_count", 32'(valid_cnt - v0), 32'd1);
    chk("baud_ferr", 32'(ferr_cnt - f0), 32'd0);

    // incrementing 256-byte stream into the fast instance
    @(posedge clk60);
    idle(20);
    for (int b = 0; b < 256; b++) begin
      send_frame(1'b1, 8'(b), 8, 1'b1);
    end
    idle(50);
    @(negedge clk60);
    chk("stream_count", 32'(valid2_cnt), 32'd256);
    chk("stream_order", 32'(mism2_cnt), 32'd0);
    chk("stream_ferr", 32'(ferr2_cnt), 32'd0);
    chk("stream_last", 32'(rxdata2), 32'hFF);

    chk("pulse_exclusive", 32'(viol_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx
